// File: rtl/hub75_scan_if.sv
// rtl/hub75_scan_if.sv - frame buffer read port between hub75_framebuf and hub75_scan
interface hub75_scan_if #(
   parameter int ADDR_W_P = 12,
   parameter int DATA_W_P = 24
);
   logic [ADDR_W_P-1:0] rd_addr;
   logic [DATA_W_P-1:0] rd_data;

   // scanner drives the address and receives data one clk later
   modport master (output rd_addr, input rd_data);
   // frame buffer answers the address with registered read data
   modport slave (input rd_addr, output rd_data);
endinterface

// File: rtl/hub75_scan.sv
// rtl/hub75_scan.sv - HUB75 row-pair scanner with BCM planes; optional global dimming via HUB75_BRIGHTNESS_EN
module hub75_scan #(
   parameter int HPIXEL_P   = 64,
   parameter int VPIXEL_P   = 64,
   parameter int BPP_P      = 8,
   parameter int BASE_CYC_P = 4,
   parameter int ADDR_W_P   = $clog2(HPIXEL_P*VPIXEL_P),
   localparam int ROW_W_P   = (VPIXEL_P > 2) ? $clog2(VPIXEL_P/2) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
`ifdef HUB75_BRIGHTNESS_EN
   input  logic [7:0]         i_brightness,
`endif
   hub75_scan_if.master       fb_if,
   output logic [2:0]         o_hub_rgb1,
   output logic [2:0]         o_hub_rgb2,
   output logic               o_hub_clk,
   output logic               o_hub_lat,
   output logic               o_hub_oe_n,
   output logic [ROW_W_P-1:0] o_hub_addr,
   output logic               o_frame_done
);
   localparam int COL_W = (HPIXEL_P > 1) ? $clog2(HPIXEL_P) : 1;
   localparam int PL_W  = (BPP_P > 1) ? $clog2(BPP_P) : 1;
   localparam int CNT_W = $clog2((BASE_CYC_P << (BPP_P - 1)) + 1);
   localparam int HALF  = VPIXEL_P / 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_DISPLAY
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [COL_W-1:0]     r_col;
   logic [1:0]           r_ph;
   logic [ROW_W_P-1:0]   r_row;
   logic [PL_W-1:0]      r_plane;
   logic [CNT_W-1:0]     r_cnt;
   logic [3*BPP_P-1:0]   r_upper;
   logic [2:0]           r_rgb1;
   logic [2:0]           r_rgb2;
   logic [ROW_W_P-1:0]   r_hub_addr;
   logic                 r_frame_done;

   logic                 w_last_col;
   logic                 w_last_row;
   logic                 w_last_plane;
   logic [CNT_W-1:0]     w_slot_len;
   logic                 w_slot_end;
   logic                 w_frame_end;
   logic                 w_on;
   logic [2:0]           w_rgb1;
   logic [2:0]           w_rgb2;
   logic                 w_rgb_phase;
   logic [ADDR_W_P-1:0]  w_addr_up;
   logic [ADDR_W_P-1:0]  w_addr_lo;
   logic [ADDR_W_P-1:0]  w_rd_addr;

   // pick bit 'pl' of each colour channel of a {R,G,B} word
   function automatic logic [2:0] plane_bits(input logic [3*BPP_P-1:0] word,
                                             input logic [PL_W-1:0] pl);
      logic [BPP_P-1:0] ch_r;
      logic [BPP_P-1:0] ch_g;
      logic [BPP_P-1:0] ch_b;
      {ch_r, ch_g, ch_b} = word;
      return {ch_r[pl], ch_g[pl], ch_b[pl]};
   endfunction

   assign w_last_col   = (r_col == COL_W'(HPIXEL_P - 1));
   assign w_last_row   = (r_row == ROW_W_P'(HALF - 1));
   assign w_last_plane = (r_plane == PL_W'(BPP_P - 1));
   assign w_slot_len   = CNT_W'(BASE_CYC_P) << r_plane;
   assign w_slot_end   = (r_cnt == w_slot_len - CNT_W'(1));
   assign w_frame_end  = (r_state == ST_DISPLAY) && w_slot_end && w_last_plane && w_last_row;

   assign w_addr_up = ADDR_W_P'(r_row) * ADDR_W_P'(HPIXEL_P) + ADDR_W_P'(r_col);
   assign w_addr_lo = (ADDR_W_P'(r_row) + ADDR_W_P'(HALF)) * ADDR_W_P'(HPIXEL_P) + ADDR_W_P'(r_col);

   // t2 shows the fresh bits straight away so they are settled before the t3 rising edge
   assign w_rgb_phase = (r_state == ST_SHIFT) && (r_ph == 2'd2);
   assign w_rgb1      = plane_bits(r_upper, r_plane);
   assign w_rgb2      = plane_bits(fb_if.rd_data, r_plane);

`ifdef HUB75_BRIGHTNESS_EN
   logic [7:0]       r_bri;
   logic [CNT_W+7:0] w_prod;

   // OE is held only for the leading bri/256 share of each BCM slot
   assign w_prod = {8'd0, w_slot_len} * {{CNT_W{1'b0}}, r_bri};
   assign w_on   = ({8'd0, r_cnt} < (w_prod >> 8));

   // brightness is frozen for a whole frame so planes stay proportional
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bri <= 8'd0;
      end else if ((r_state == ST_IDLE && i_en) || (w_frame_end && i_en)) begin
         r_bri <= i_brightness;
      end
   end
`else
   assign w_on = 1'b1;
`endif

   // state register, counters and captured pixel data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_col        <= '0;
         r_ph         <= 2'd0;
         r_row        <= '0;
         r_plane      <= '0;
         r_cnt        <= '0;
         r_upper      <= '0;
         r_rgb1       <= 3'd0;
         r_rgb2       <= 3'd0;
         r_hub_addr   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_frame_done <= w_frame_end;
         case (r_state)
            ST_IDLE: begin
               r_col <= '0;
               r_ph  <= 2'd0;
               r_cnt <= '0;
            end
            ST_SHIFT: begin
               r_ph <= r_ph + 2'd1;
               if (r_ph == 2'd1) begin
                  r_upper <= fb_if.rd_data;
               end
               if (r_ph == 2'd2) begin
                  r_rgb1 <= w_rgb1;
                  r_rgb2 <= w_rgb2;
               end
               if (r_ph == 2'd3) begin
                  r_col <= w_last_col ? '0 : r_col + COL_W'(1);
               end
            end
            ST_BLANK: begin
               r_hub_addr <= r_row;
            end
            ST_LATCH: begin
               r_cnt <= '0;
            end
            ST_DISPLAY: begin
               if (w_slot_end) begin
                  r_cnt <= '0;
                  if (w_last_plane) begin
                     r_plane <= '0;
                     r_row   <= w_last_row ? '0 : r_row + ROW_W_P'(1);
                  end else begin
                     r_plane <= r_plane + PL_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   // next state and panel strobes decoded from the current state
   always_comb begin
      w_next     = r_state;
      w_rd_addr  = '0;
      o_hub_clk  = 1'b0;
      o_hub_lat  = 1'b0;
      o_hub_oe_n = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (i_en) begin
               w_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_rd_addr = (r_ph == 2'd1) ? w_addr_lo : w_addr_up;
            o_hub_clk = (r_ph == 2'd3);
            if (r_ph == 2'd3 && w_last_col) begin
               w_next = ST_BLANK;
            end
         end
         ST_BLANK: begin
            w_next = ST_LATCH;
         end
         ST_LATCH: begin
            o_hub_lat = 1'b1;
            w_next    = ST_DISPLAY;
         end
         ST_DISPLAY: begin
            o_hub_oe_n = ~w_on;
            if (w_slot_end) begin
               w_next = (w_last_plane && w_last_row && !i_en) ? ST_IDLE : ST_SHIFT;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign fb_if.rd_addr = w_rd_addr;
   assign o_hub_rgb1    = w_rgb_phase ? w_rgb1 : r_rgb1;
   assign o_hub_rgb2    = w_rgb_phase ? w_rgb2 : r_rgb2;
   assign o_hub_addr    = r_hub_addr;
   assign o_frame_done  = r_frame_done;
endmodule

// File: tb/tb_hub75_scan.sv
// tb/tb_hub75_scan.sv - scoreboard bench for hub75_scan on a reduced 8x8 panel
module tb_hub75_scan;
   localparam int HP   = 8;
   localparam int VP   = 8;
   localparam int BPP  = 8;
   localparam int BASE = 4;
   localparam int AW   = $clog2(HP*VP);
   localparam int DW   = 3*BPP;
   localparam int RW   = $clog2(VP/2);
`ifdef HUB75_BRIGHTNESS_EN
   localparam int BRI  = 128;
   logic [7:0] bri = 8'(BRI);
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic [2:0]    hub_rgb1;
   logic [2:0]    hub_rgb2;
   logic          hub_clk;
   logic          hub_lat;
   logic          hub_oe_n;
   logic [RW-1:0] hub_addr;
   logic          frame_done;

   logic [DW-1:0] mem [HP*VP];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   bit            mon_en = 1'b0;

   logic [5:0]    q_rgb[$];
   int            q_oe_len[$];
   int            q_oe_row[$];
   int            q_done[$];

   hub75_scan_if #(.ADDR_W_P(AW), .DATA_W_P(DW)) fb_bus ();

   hub75_scan #(
      .HPIXEL_P(HP), .VPIXEL_P(VP), .BPP_P(BPP), .BASE_CYC_P(BASE), .ADDR_W_P(AW)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_en         (en),
`ifdef HUB75_BRIGHTNESS_EN
      .i_brightness (bri),
`endif
      .fb_if        (fb_bus),
      .o_hub_rgb1   (hub_rgb1),
      .o_hub_rgb2   (hub_rgb2),
      .o_hub_clk    (hub_clk),
      .o_hub_lat    (hub_lat),
      .o_hub_oe_n   (hub_oe_n),
      .o_hub_addr   (hub_addr),
      .o_frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) fb_bus.rd_data <= mem[fb_bus.rd_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int frame_cyc();
      int t = 0;
      for (int b = 0; b < BPP; b++) t += 4*HP + 2 + (BASE << b);
      return t * (VP/2);
   endfunction

   task automatic push_frame(input int start);
      logic [DW-1:0] up;
      logic [DW-1:0] lo;
      int            len;
      for (int r = 0; r < VP/2; r++) begin
         for (int b = 0; b < BPP; b++) begin
            for (int c = 0; c < HP; c++) begin
               up = mem[r*HP + c];
               lo = mem[(r + VP/2)*HP + c];
               q_rgb.push_back({up[2*BPP+b], up[BPP+b], up[b], lo[2*BPP+b], lo[BPP+b], lo[b]});
            end
            len = BASE << b;
`ifdef HUB75_BRIGHTNESS_EN
            len = (len * BRI) >> 8;
`endif
            if (len > 0) begin
               q_oe_len.push_back(len);
               q_oe_row.push_back(r);
            end
         end
      end
      q_done.push_back(start + frame_cyc());
   endtask

   task automatic wait_done(input int limit);
      bit seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (frame_done) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
   endtask

   // monitor: pop expectations as the panel-side strobes occur
   logic          prev_hclk = 1'b0;
   logic          prev_oe_n = 1'b1;
   int            rises = 0;
   int            last_rise = 0;
   int            oe_run = 0;
   logic [RW-1:0] oe_addr = '0;
   bit            addr_moved = 1'b0;
   always @(negedge clk) begin
      if (!mon_en) begin
         rises = 0;
      end else begin
         if (hub_clk && !prev_hclk) begin
            rises++;
            last_rise = cyc;
            if (q_rgb.size() == 0) check("rgb_extra", 32'd1, 32'd0);
            else check("rgb", 32'({hub_rgb1, hub_rgb2}), 32'(q_rgb.pop_front()));
         end
         if (hub_lat) begin
            check("lat_rises", 32'(rises), 32'(HP));
            check("lat_gap", 32'(cyc - last_rise), 32'd2);
            rises = 0;
         end
         if (!hub_oe_n) begin
            if (prev_oe_n) begin
               oe_run     = 0;
               oe_addr    = hub_addr;
               addr_moved = 1'b0;
            end
            oe_run++;
            if (hub_addr != oe_addr) addr_moved = 1'b1;
         end else if (!prev_oe_n) begin
            if (q_oe_len.size() == 0) check("oe_extra", 32'd1, 32'd0);
            else begin
               check("oe_len", 32'(oe_run), 32'(q_oe_len.pop_front()));
               check("oe_addr", 32'(oe_addr), 32'(q_oe_row.pop_front()));
               check("oe_addr_stable", 32'(addr_moved), 32'd0);
            end
         end
         if (frame_done) begin
            if (q_done.size() == 0) check("done_extra", 32'd1, 32'd0);
            else check("done_cyc", 32'(cyc), 32'(q_done.pop_front()));
         end
      end
      prev_hclk = hub_clk;
      prev_oe_n = hub_oe_n;
   end

   initial begin
      int lows;
      int hcs;
      for (int i = 0; i < HP*VP; i++) mem[i] = '0;

      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_oe_n", 32'(hub_oe_n), 32'd1);
      check("rst_lat", 32'(hub_lat), 32'd0);
      check("rst_hclk", 32'(hub_clk), 32'd0);
      check("rst_rgb1", 32'(hub_rgb1), 32'd0);
      check("rst_rgb2", 32'(hub_rgb2), 32'd0);
      check("rst_addr", 32'(hub_addr), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_rd_addr", 32'(fb_bus.rd_addr), 32'd0);

      rst = 1'b0;
      en  = 1'b1;
      repeat (20) @(negedge clk);
      check("mid_shift_oe_n", 32'(hub_oe_n), 32'd1);
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_mid_oe_n", 32'(hub_oe_n), 32'd1);
         check("rst_mid_lat", 32'(hub_lat), 32'd0);
         check("rst_mid_hclk", 32'(hub_clk), 32'd0);
         check("rst_mid_rd_addr", 32'(fb_bus.rd_addr), 32'd0);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_oe_n", 32'(hub_oe_n), 32'd1);
      check("idle_hclk", 32'(hub_clk), 32'd0);

      mem[0] = 24'h800000;
      mem[(VP/2)*HP + HP - 1] = 24'h000100;
      push_frame(cyc + 1);
      mon_en = 1'b1;
      en     = 1'b1;
      wait_done(frame_cyc() + 100);

      for (int i = 0; i < HP*VP; i++) mem[i] = DW'($urandom);
      push_frame(cyc);
      repeat (frame_cyc() / 2) @(negedge clk);
      en = 1'b0;
      wait_done(frame_cyc());

      lows = 0;
      hcs  = 0;
      repeat (40) begin
         @(negedge clk);
         if (!hub_oe_n) lows++;
         if (hub_clk) hcs++;
      end
      check("after_idle_oe_low", 32'(lows), 32'd0);
      check("after_idle_hclk", 32'(hcs), 32'd0);
      check("q_rgb_left", 32'(q_rgb.size()), 32'd0);
      check("q_oe_left", 32'(q_oe_len.size()), 32'd0);
      check("q_done_left", 32'(q_done.size()), 32'd0);
      mon_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
